pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised program-counter and call-stack sequencer that replaces the fixed 16-bit PC and 256-entry address stack inside the control unit.
- Executes one flow command per cycle from the control decoder: increment, skip, jump, call, return and optional interrupt entry/return.
- Call stack is a single-port synchronous-read memory, BRAM-mappable, so RET is a two-cycle operation with a busy handshake.
- Adds overflow/underflow detection and explicit stack status. `pc` drives the ROM address.

Parameters:
- ADDR_W, 16, PC and stack entry width.
- DEPTH, 256, number of call-stack entries (≥2).
- RESET_VEC, 0, PC value after reset.
- IRQ_VEC, 16'h0004, interrupt entry address (used only with the optional feature).

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present this cycle
- cmd  in  3  0 HOLD, 1 INC, 2 JMP, 3 CALL, 4 RET, 5 SKIP, 6 RETI, 7 reserved
- target  in  ADDR_W  jump/call destination
- err_clr  in  1  clears sticky ovf/unf
- irq  in  1  interrupt request, level
- pc  out  ADDR_W  current program counter
- busy  out  1  RET/RETI in progress; commands ignored
- sp  out  $clog2(DEPTH+1)  stack occupancy, 0..DEPTH
- stk_full  out  1  sp==DEPTH
- stk_empty  out  1  sp==0
- ovf  out  1  sticky: CALL attempted while full
- unf  out  1  sticky: RET attempted while empty
- irq_ack  out  1  one-cycle pulse on interrupt entry
- ie  out  1  interrupt enable

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_VEC, sp=0, busy=0, ovf=0, unf=0, irq_ack=0, ie=1.
  - FSM returns to IDLE; any in-flight RET is abandoned.
  - Stack memory contents are not cleared.
- FSM states: IDLE, POP.
- Commands are accepted only in IDLE with cmd_valid=1. cmd_valid=0 or HOLD leaves pc unchanged.
- INC: pc<=pc+1 next edge.
- SKIP: pc<=pc+2.
- JMP: pc<=target.
- Reserved code 7 behaves as HOLD.
- PC arithmetic is modulo 2^ADDR_W and wraps silently.
- CALL, not full:
  - mem[sp]<=pc+1 (wrapped), sp<=sp+1, pc<=target, all in the same edge.
- CALL, full:
  - No push; pc holds; ovf<=1.
- RET, not empty:
  - Edge 1: memory read at sp-1 is issued, FSM→POP, busy=1.
  - Edge 2: pc<=read data, sp<=sp-1, FSM→IDLE, busy=0.
  - Result: pc updates 2 cycles after RET is sampled.
  - Commands presented while busy=1 are dropped, not queued.
- RET, empty:
  - pc holds; unf<=1; no POP state entered.
- Sticky flags: err_clr clears ovf/unf. If a new error occurs on the same edge as err_clr, the flag is set (error wins).
- stk_full and stk_empty are combinational from sp.
- Memory has one port, so at most one read or one write per cycle. A CALL immediately after a RET completes is legal and writes the freshly freed slot.

Optional Feature:
- Macro: PC_SEQUENCER_IRQ_EN
- Defined:
  - Interrupt is taken when state=IDLE, ie=1, irq=1, cmd_valid=1, cmd=INC (sequential instruction boundary) and stack not full.
  - INC is replaced by: push pc+1, pc<=IRQ_VEC, ie<=0, sp+1, irq_ack=1 for one cycle.
  - irq while full: ovf<=1, interrupt not taken, INC executes normally.
  - RETI: identical to RET and additionally sets ie<=1 on the POP edge. RETI on empty sets unf and leaves ie unchanged.
- Undefined:
  - irq ignored, irq_ack tied 0, ie constant 1.
  - RETI behaves exactly as RET.
  - Ports are present in both builds.

Test Plan:
- Reset/basic flow: assert RST_N=0 mid-cycle → pc=0, sp=0, stk_empty=1 immediately. Release, INC×3 → pc=3. JMP 0x0100 → pc=0x0100 next edge.
- Call/return and busy: at pc=0x0100, CALL 0x0200 → pc=0x0200, sp=1. RET → busy=1 one cycle, then pc=0x0101, sp=0. A JMP 0x0300 presented during busy is ignored.
- Overflow and underflow (DEPTH=4):
  - Five CALLs → fifth sets ovf=1, stk_full=1, pc unchanged, sp=4.
  - Drain with four RETs, then a fifth RET → unf=1, pc held.
  - err_clr together with another empty RET → unf stays 1.
- PC wrap: pc=0xFFFF, INC → 0x0000. At 0xFFFF, SKIP → 0x0001. CALL at 0xFFFF pushes 0x0000, and RET restores pc=0x0000.
- Reset mid-operation: assert RST_N during the POP cycle → pc=RESET_VEC, sp=0, busy=0. After release the next command executes normally.
- IRQ build: irq=1 with INC at pc=0x0010 → pc=0x0004, irq_ack pulses one cycle, ie=0, sp=1. A second irq is ignored while ie=0. RETI → pc=0x0011, ie=1 on the same edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter with a BRAM-style call stack (one port, synchronous read), so RET takes two cycles.
// Optional interrupt entry/return is enabled by defining PC_SEQUENCER_IRQ_EN.
module pc_sequencer #(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DEPTH     = 256,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] IRQ_VEC   = ADDR_W'(16'h0004)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cmd_valid_i,
  input  logic [2:0]                 cmd_i,
  input  logic [ADDR_W-1:0]          target_i,
  input  logic                       err_clr_i,
  input  logic                       irq_i,
  output logic [ADDR_W-1:0]          pc_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH+1)-1:0] sp_o,
  output logic                       stk_full_o,
  output logic                       stk_empty_o,
  output logic                       ovf_o,
  output logic                       unf_o,
  output logic                       irq_ack_o,
  output logic                       ie_o
);

  localparam int unsigned SpW  = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = $clog2(DEPTH);

  localparam logic [2:0] CmdInc  = 3'd1;
  localparam logic [2:0] CmdJmp  = 3'd2;
  localparam logic [2:0] CmdCall = 3'd3;
  localparam logic [2:0] CmdRet  = 3'd4;
  localparam logic [2:0] CmdSkip = 3'd5;
  localparam logic [2:0] CmdReti = 3'd6;

  typedef enum logic [0:0] {StIdle, StPop} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SpW-1:0]    sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] rd_data_q;
  logic              mem_we;
  logic [IdxW-1:0]   mem_addr;
  logic [ADDR_W-1:0] mem_wdata;

  logic full, empty, accept, is_ret, pop_start;
  logic irq_take, irq_ovf;

  assign full   = (sp_q == SpW'(DEPTH));
  assign empty  = (sp_q == '0);
  assign accept = (state_q == StIdle) && cmd_valid_i;
  assign is_ret = (cmd_i == CmdRet) || (cmd_i == CmdReti);

`ifdef PC_SEQUENCER_IRQ_EN
  logic ie_q, ie_d;
  logic irq_ack_q;
  logic reti_q, reti_d;
  logic irq_req;

  // Interrupts are only taken at a sequential-instruction boundary (INC).
  assign irq_req  = accept && (cmd_i == CmdInc) && ie_q && irq_i;
  assign irq_take = irq_req && !full;
  assign irq_ovf  = irq_req && full;

  always_comb begin
    ie_d   = ie_q;
    reti_d = reti_q;
    if (irq_take) begin
      ie_d = 1'b0;
    end
    if (pop_start) begin
      reti_d = (cmd_i == CmdReti);
    end
    if ((state_q == StPop) && reti_q) begin
      ie_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ie_q      <= 1'b1;
      irq_ack_q <= 1'b0;
      reti_q    <= 1'b0;
    end else begin
      ie_q      <= ie_d;
      irq_ack_q <= irq_take;
      reti_q    <= reti_d;
    end
  end

  assign ie_o      = ie_q;
  assign irq_ack_o = irq_ack_q;
`else
  logic unused_irq;

  assign irq_take   = 1'b0;
  assign irq_ovf    = 1'b0;
  assign unused_irq = irq_i ^ (|IRQ_VEC);
  assign ie_o       = 1'b1;
  assign irq_ack_o  = 1'b0;
`endif

  assign pop_start = accept && is_ret && !empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pop_start) state_d = StPop;
      StPop:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o = (state_q == StPop);
  end

  always_comb begin
    pc_d      = pc_q;
    sp_d      = sp_q;
    ovf_d     = ovf_q & ~err_clr_i;
    unf_d     = unf_q & ~err_clr_i;
    mem_we    = 1'b0;
    mem_addr  = IdxW'(sp_q - SpW'(1));
    mem_wdata = pc_q + ADDR_W'(1);
    if (state_q == StPop) begin
      pc_d = rd_data_q;
      sp_d = sp_q - SpW'(1);
    end else if (accept) begin
      if (irq_take) begin
        mem_we   = 1'b1;
        mem_addr = IdxW'(sp_q);
        sp_d     = sp_q + SpW'(1);
        pc_d     = IRQ_VEC;
      end else begin
        case (cmd_i)
          CmdInc:  pc_d = pc_q + ADDR_W'(1);
          CmdSkip: pc_d = pc_q + ADDR_W'(2);
          CmdJmp:  pc_d = target_i;
          CmdCall: begin
            if (full) begin
              ovf_d = 1'b1;
            end else begin
              mem_we   = 1'b1;
              mem_addr = IdxW'(sp_q);
              sp_d     = sp_q + SpW'(1);
              pc_d     = target_i;
            end
          end
          CmdRet, CmdReti: if (empty) unf_d = 1'b1;
          default: ;
        endcase
      end
      if (irq_ovf) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q  <= RESET_VEC;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Read-first single port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
    rd_data_q <= mem_q[mem_addr];
  end

  assign pc_o        = pc_q;
  assign sp_o        = sp_q;
  assign stk_full_o  = full;
  assign stk_empty_o = empty;
  assign ovf_o       = ovf_q;
  assign unf_o       = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a 4-entry stack; covers the interrupt path when
// PC_SEQUENCER_IRQ_EN is defined and the tied-off behaviour otherwise.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd = 3'd0;
  logic [15:0] target = 16'h0;
  logic        err_clr = 1'b0;
  logic        irq = 1'b0;
  logic [15:0] pc;
  logic        busy;
  logic [2:0]  sp;
  logic        stk_full, stk_empty, ovf, unf, irq_ack, ie;

  int total = 0;
  int bad = 0;

  pc_sequencer #(
    .ADDR_W(16),
    .DEPTH(4),
    .RESET_VEC(16'h0000),
    .IRQ_VEC(16'h0004)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_i(cmd),
    .target_i(target),
    .err_clr_i(err_clr),
    .irq_i(irq),
    .pc_o(pc),
    .busy_o(busy),
    .sp_o(sp),
    .stk_full_o(stk_full),
    .stk_empty_o(stk_empty),
    .ovf_o(ovf),
    .unf_o(unf),
    .irq_ack_o(irq_ack),
    .ie_o(ie)
  );

  always #5 clk = ~clk;

  // Called at a falling edge; presents one command across the next rising edge.
  task automatic issue(input logic [2:0] c, input logic [15:0] t);
    cmd_valid = 1'b1;
    cmd       = c;
    target    = t;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd       = 3'd0;
  endtask

  task automatic test_reset();
    total++; if ({pc, sp, busy, stk_empty, ovf, unf, irq_ack, ie} !== {16'h0, 3'd0, 6'b010001}) begin
      bad++; $display("FAIL reset_release got=%h want=%h", {pc, sp, busy, stk_empty, ovf, unf, irq_ack, ie},
                      {16'h0, 3'd0, 6'b010001});
    end
    issue(3'd1, 16'h0);
    issue(3'd3, 16'h0040);
    total++; if ({pc, sp} !== {16'h0040, 3'd1}) begin
      bad++; $display("FAIL pre_reset_call got=%h want=%h", {pc, sp}, {16'h0040, 3'd1});
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({pc, sp, stk_empty, busy} !== {16'h0, 3'd0, 2'b10}) begin
      bad++; $display("FAIL async_reset got=%h want=%h", {pc, sp, stk_empty, busy}, {16'h0, 3'd0, 2'b10});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    issue(3'd1, 16'h0); issue(3'd1, 16'h0); issue(3'd1, 16'h0);
    total++; if (pc !== 16'h0003) begin bad++; $display("FAIL inc3 got=%h want=%h", pc, 16'h0003); end
    issue(3'd0, 16'h0); issue(3'd7, 16'h0999);
    cmd = 3'd1; @(negedge clk); cmd = 3'd0;
    total++; if (pc !== 16'h0003) begin bad++; $display("FAIL hold got=%h want=%h", pc, 16'h0003); end
    issue(3'd5, 16'h0);
    total++; if (pc !== 16'h0005) begin bad++; $display("FAIL skip got=%h want=%h", pc, 16'h0005); end
    issue(3'd2, 16'h0100);
    total++; if (pc !== 16'h0100) begin bad++; $display("FAIL jmp got=%h want=%h", pc, 16'h0100); end
  endtask

  task automatic test_call_ret();
    issue(3'd3, 16'h0200);
    total++; if ({pc, sp} !== {16'h0200, 3'd1}) begin
      bad++; $display("FAIL call got=%h want=%h", {pc, sp}, {16'h0200, 3'd1});
    end
    issue(3'd4, 16'h0);
    total++; if ({busy, pc, sp} !== {1'b1, 16'h0200, 3'd1}) begin
      bad++; $display("FAIL ret_busy got=%h want=%h", {busy, pc, sp}, {1'b1, 16'h0200, 3'd1});
    end
    issue(3'd2, 16'h0300);
    total++; if ({busy, pc, sp} !== {1'b0, 16'h0101, 3'd0}) begin
      bad++; $display("FAIL ret_done got=%h want=%h", {busy, pc, sp}, {1'b0, 16'h0101, 3'd0});
    end
    @(negedge clk);
    total++; if (pc !== 16'h0101) begin bad++; $display("FAIL busy_drop got=%h want=%h", pc, 16'h0101); end
  endtask

  task automatic test_ovf_unf();
    logic [15:0] exp_pc [4] = '{16'h0031, 16'h0021, 16'h0011, 16'h0102};
    issue(3'd3, 16'h0010); issue(3'd3, 16'h0020); issue(3'd3, 16'h0030); issue(3'd3, 16'h0040);
    issue(3'd3, 16'h0050);
    total++; if ({ovf, stk_full, pc, sp} !== {2'b11, 16'h0040, 3'd4}) begin
      bad++; $display("FAIL ovf got=%h want=%h", {ovf, stk_full, pc, sp}, {2'b11, 16'h0040, 3'd4});
    end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b want=0", ovf); end
    for (int i = 0; i < 4; i++) begin
      issue(3'd4, 16'h0);
      @(negedge clk);
      total++; if ({pc, sp} !== {exp_pc[i], 3'(3 - i)}) begin
        bad++; $display("FAIL drain%0d got=%h want=%h", i, {pc, sp}, {exp_pc[i], 3'(3 - i)});
      end
    end
    issue(3'd4, 16'h0);
    total++; if ({unf, busy, pc, stk_empty} !== {2'b10, 16'h0102, 1'b1}) begin
      bad++; $display("FAIL unf got=%h want=%h", {unf, busy, pc, stk_empty}, {2'b10, 16'h0102, 1'b1});
    end
    err_clr = 1'b1; issue(3'd4, 16'h0); err_clr = 1'b0;
    total++; if (unf !== 1'b1) begin bad++; $display("FAIL unf_err_wins got=%b want=1", unf); end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    total++; if (unf !== 1'b0) begin bad++; $display("FAIL unf_clr got=%b want=0", unf); end
  endtask

  task automatic test_wrap();
    issue(3'd2, 16'hFFFF); issue(3'd1, 16'h0);
    total++; if (pc !== 16'h0000) begin bad++; $display("FAIL wrap_inc got=%h want=0000", pc); end
    issue(3'd2, 16'hFFFF); issue(3'd5, 16'h0);
    total++; if (pc !== 16'h0001) begin bad++; $display("FAIL wrap_skip got=%h want=0001", pc); end
    issue(3'd2, 16'hFFFF); issue(3'd3, 16'h1234);
    issue(3'd4, 16'h0); @(negedge clk);
    total++; if ({pc, sp} !== {16'h0000, 3'd0}) begin
      bad++; $display("FAIL wrap_call_ret got=%h want=%h", {pc, sp}, {16'h0000, 3'd0});
    end
  endtask

  task automatic test_reset_mid();
    issue(3'd2, 16'h0050); issue(3'd3, 16'h0060); issue(3'd4, 16'h0);
    rst_n = 1'b0;
    #1;
    total++; if ({pc, sp, busy} !== {16'h0, 3'd0, 1'b0}) begin
      bad++; $display("FAIL reset_in_pop got=%h want=%h", {pc, sp, busy}, {16'h0, 3'd0, 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3'd1, 16'h0);
    total++; if ({pc, busy} !== {16'h0001, 1'b0}) begin
      bad++; $display("FAIL after_reset got=%h want=%h", {pc, busy}, {16'h0001, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    issue(3'd2, 16'h0010); issue(3'd3, 16'h0020);
    issue(3'd4, 16'h0); @(negedge clk);
    issue(3'd3, 16'h0080);
    total++; if ({pc, sp} !== {16'h0080, 3'd1}) begin
      bad++; $display("FAIL b2b_call got=%h want=%h", {pc, sp}, {16'h0080, 3'd1});
    end
    issue(3'd4, 16'h0); @(negedge clk);
    total++; if ({pc, sp} !== {16'h0012, 3'd0}) begin
      bad++; $display("FAIL b2b_ret got=%h want=%h", {pc, sp}, {16'h0012, 3'd0});
    end
  endtask

  task automatic test_irq();
    issue(3'd2, 16'h0010);
    irq = 1'b1;
`ifdef PC_SEQUENCER_IRQ_EN
    issue(3'd1, 16'h0);
    total++; if ({pc, irq_ack, ie, sp} !== {16'h0004, 2'b10, 3'd1}) begin
      bad++; $display("FAIL irq_entry got=%h want=%h", {pc, irq_ack, ie, sp}, {16'h0004, 2'b10, 3'd1});
    end
    issue(3'd1, 16'h0);
    total++; if ({pc, irq_ack, sp} !== {16'h0005, 1'b0, 3'd1}) begin
      bad++; $display("FAIL irq_masked got=%h want=%h", {pc, irq_ack, sp}, {16'h0005, 1'b0, 3'd1});
    end
    irq = 1'b0;
    issue(3'd6, 16'h0);
    total++; if ({busy, ie} !== 2'b10) begin
      bad++; $display("FAIL reti_busy got=%b want=10", {busy, ie});
    end
    @(negedge clk);
    total++; if ({pc, ie, sp} !== {16'h0011, 1'b1, 3'd0}) begin
      bad++; $display("FAIL reti got=%h want=%h", {pc, ie, sp}, {16'h0011, 1'b1, 3'd0});
    end
`else
    issue(3'd1, 16'h0);
    total++; if ({pc, irq_ack, ie, sp} !== {16'h0011, 2'b01, 3'd0}) begin
      bad++; $display("FAIL irq_ignored got=%h want=%h", {pc, irq_ack, ie, sp}, {16'h0011, 2'b01, 3'd0});
    end
    irq = 1'b0;
    issue(3'd3, 16'h0040); issue(3'd6, 16'h0); @(negedge clk);
    total++; if ({pc, ie, sp} !== {16'h0012, 1'b1, 3'd0}) begin
      bad++; $display("FAIL reti_as_ret got=%h want=%h", {pc, ie, sp}, {16'h0012, 1'b1, 3'd0});
    end
`endif
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_call_ret();
    test_ovf_unf();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_irq();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
